// File: rtl/uart_tx_buf.sv
// UART transmitter, 16x oversampled, with a one-entry holding register.
// A byte can queue while the current frame shifts, so frames go out back-to-back.
// Frame: start bit, WordLength data bits LSB-first, stop period of StopBitTicks ticks.
module uart_tx_buf #(
    parameter int unsigned WordLength   = 8,
    parameter int unsigned StopBitTicks = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sample_tick_i,
    input  logic [7:0] din_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       tx_o,
    output logic       tx_busy_o,
    output logic       tx_done_tick_o
);

    localparam int unsigned DataW  = 8;
    localparam int unsigned TickW  = 5;
    localparam int unsigned BitW   = 3;
    localparam int unsigned StateW = 2;

    localparam logic [StateW-1:0] IDLE  = 2'd0;
    localparam logic [StateW-1:0] START = 2'd1;
    localparam logic [StateW-1:0] DATA  = 2'd2;
    localparam logic [StateW-1:0] STOP  = 2'd3;

    localparam logic [TickW-1:0] BitLastTick  = TickW'(15);
    localparam logic [TickW-1:0] StopLastTick = TickW'(StopBitTicks - 1);
    localparam logic [BitW-1:0]  LastBit      = BitW'(WordLength - 1);
    localparam logic [DataW-1:0] DataMask     = DataW'((32'd1 << WordLength) - 32'd1);

    logic [StateW-1:0] state_q, state_d;
    logic [TickW-1:0]  tick_q, tick_d;
    logic [BitW-1:0]   bit_q, bit_d;
    logic [DataW-1:0]  shift_q, shift_d;
    logic [DataW-1:0]  hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              load;
    logic              accept;

    // State and datapath registers; reset aborts any frame and idles the line high
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            tick_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
        end
    end

    // Next-state, counters, holding-register handshake and registered outputs
    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        done_d      = 1'b0;
        load        = 1'b0;
        // ready is ~hold_full, so an accept can never coincide with a load
        accept      = tx_valid_i & ~hold_full_q;

        case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    load    = 1'b1;
                    tick_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (sample_tick_i) begin
                    if (tick_q == BitLastTick) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = DATA;
                    end else begin
                        tick_d = tick_q + TickW'(1);
                    end
                end
            end
            DATA: begin
                if (sample_tick_i) begin
                    if (tick_q == BitLastTick) begin
                        tick_d  = '0;
                        shift_d = shift_q >> 1;
                        if (bit_q == LastBit) begin
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + BitW'(1);
                        end
                    end else begin
                        tick_d = tick_q + TickW'(1);
                    end
                end
            end
            STOP: begin
                if (sample_tick_i) begin
                    if (tick_q == StopLastTick) begin
                        done_d = 1'b1;
                        tick_d = '0;
                        if (hold_full_q) begin
                            load    = 1'b1;
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_d = tick_q + TickW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
        end
        if (accept) begin
            hold_d      = din_i & DataMask;
            hold_full_d = 1'b1;
        end

        // Line level follows the state being entered so it changes on the same edge
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        busy_d  = (state_d != IDLE);
        ready_d = ~hold_full_d;
    end

    assign tx_o           = tx_q;
    assign tx_busy_o      = busy_q;
    assign tx_ready_o     = ready_q;
    assign tx_done_tick_o = done_q;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Self-checking bench for uart_tx_buf: directed scenarios plus a random loopback run.
module tb_uart_tx_buf;

    localparam int unsigned FrameTicks  = 16 + 16 * 8 + 16;
    localparam int unsigned Frame2Ticks = 16 + 16 * 7 + 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sample_tick = 1'b0;
    logic [7:0] din = 8'h00, din2 = 8'h00;
    logic       valid = 1'b0, valid2 = 1'b0;
    logic       ready, tx, busy, done;
    logic       ready2, tx2, busy2, done2;

    int checks = 0;
    int failures = 0;
    int tick_div = 4;
    int tick_ph = 0;

    // Reference-model state: bytes accepted but not yet seen on the line
    logic [7:0] exp_q[$];
    logic       done_tx_q[$];
    bit         mon_in = 1'b0;
    bit         done_exp = 1'b0;
    int         mon_idx = 0;
    int         mon_frames = 0;
    int         done_cnt = 0;
    logic [7:0] mon_byte = 8'h00;

    uart_tx_buf dut (
        .clk_i(clk), .rst_i(rst), .sample_tick_i(sample_tick),
        .din_i(din), .tx_valid_i(valid), .tx_ready_o(ready),
        .tx_o(tx), .tx_busy_o(busy), .tx_done_tick_o(done)
    );

    uart_tx_buf #(.WordLength(7), .StopBitTicks(32)) dut2 (
        .clk_i(clk), .rst_i(rst), .sample_tick_i(sample_tick),
        .din_i(din2), .tx_valid_i(valid2), .tx_ready_o(ready2),
        .tx_o(tx2), .tx_busy_o(busy2), .tx_done_tick_o(done2)
    );

    always #5 clk = ~clk;

    // Sample-tick generator: one-clock pulse every tick_div clocks
    always begin
        @(posedge clk);
        #1;
        tick_ph = (tick_ph + 1 >= tick_div) ? 0 : tick_ph + 1;
        sample_tick = (tick_ph == 0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Ideal line level at tick index idx of a default-parameter frame carrying b
    function automatic logic line_at(input logic [7:0] b, input int idx);
        if (idx < 16) return 1'b0;
        if (idx < 16 + 16 * 8) return b[(idx - 16) / 16];
        return 1'b1;
    endfunction

    // Receiver model on dut's line: decodes frames tick by tick and predicts done pulses
    always @(negedge clk) begin
        if (rst) begin
            mon_in = 1'b0;
            done_exp = 1'b0;
            mon_idx = 0;
        end else begin
            chk("done_tick", done, done_exp);
            done_exp = 1'b0;
            if (sample_tick) begin
                if (!mon_in) begin
                    if (tx === 1'b0) begin
                        mon_in = 1'b1;
                        mon_idx = 1;
                        chk("frame_was_queued", exp_q.size() != 0, 1);
                        mon_byte = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
                    end
                end else begin
                    chk("tx_line", tx, line_at(mon_byte, mon_idx));
                    mon_idx++;
                    if (mon_idx == FrameTicks) begin
                        mon_in = 1'b0;
                        done_exp = 1'b1;
                        mon_frames++;
                    end
                end
            end
        end
    end

    // Done-pulse counter; also records the line level seen during each pulse
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            done_tx_q.push_back(tx);
        end
    end

    // Offer a byte (called at a negedge); returns at the negedge after acceptance
    task automatic send(input bit sel, input logic [7:0] b, input int budget);
        bit ok = 1'b0;
        if (sel) begin din2 = b; valid2 = 1'b1; end
        else begin din = b; valid = 1'b1; end
        for (int k = 0; k < budget && !ok; k++) begin
            if ((sel ? ready2 : ready) === 1'b1) begin
                ok = 1'b1;
                if (!sel) exp_q.push_back(b);
            end
            @(negedge clk);
        end
        valid = 1'b0;
        valid2 = 1'b0;
        chk("send_accepted", ok, 1);
    endtask

    task automatic wait_done(input int target, input int budget);
        int k = 0;
        while (done_cnt < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("done_within_budget", done_cnt >= target, 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int base;
        int bad;
        int k;
        bit seen;
        logic samples[$];

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tx2", tx2, 1);
        #2 rst = 1'b0;
        @(negedge clk);

        // Single frame 0xA5, tick every 4 clocks
        base = done_cnt;
        send(0, 8'hA5, 20);
        repeat (10) @(negedge clk);
        chk("t1_busy_mid", busy, 1);
        chk("t1_tx_start", tx, 0);
        wait_done(base + 1, 3000);
        chk("t1_one_done", done_cnt - base, 1);
        chk("t1_idle_tx", tx, 1);
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_ready", ready, 1);

        // Back-to-back frames and backpressure on a third byte
        base = done_cnt;
        done_tx_q.delete();
        send(0, 8'h55, 20);
        chk("t2_ready_after_accept", ready, 0);
        send(0, 8'h0F, 20);
        chk("t2_ready_second_held", ready, 0);
        chk("t2_busy", busy, 1);
        din = 8'h33;
        valid = 1'b1;
        repeat (20) @(negedge clk);
        chk("t3_backpressure_ready", ready, 0);
        chk("t3_no_done_yet", done_cnt - base, 0);
        send(0, 8'h33, 3000);
        chk("t3_accept_after_load", done_cnt - base, 1);
        wait_done(base + 3, 3000);
        chk("t2_three_done", done_cnt - base, 3);
        chk("t2_no_gap_1", done_tx_q[0], 0);
        chk("t2_no_gap_2", done_tx_q[1], 0);
        chk("t3_last_idle", done_tx_q[2], 1);
        chk("t3_queue_empty", exp_q.size(), 0);
        chk("t3_busy_end", busy, 0);

        // WordLength=7, StopBitTicks=32, 0xFF: capture tick samples until done
        tick_div = 1;
        repeat (4) @(negedge clk);
        send(1, 8'hFF, 20);
        seen = 1'b0;
        samples.delete();
        k = 0;
        while (!seen && k < 1000) begin
            if (done2 === 1'b1) seen = 1'b1;
            else if (sample_tick && (samples.size() != 0 || tx2 === 1'b0)) samples.push_back(tx2);
            if (!seen) @(negedge clk);
            k++;
        end
        chk("t4_done_seen", seen, 1);
        chk("t4_frame_ticks", samples.size(), Frame2Ticks);
        bad = 0;
        foreach (samples[i]) if (samples[i] !== ((i < 16) ? 1'b0 : 1'b1)) bad++;
        chk("t4_frame_bits", bad, 0);
        chk("t4_busy_at_done", busy2, 0);
        @(negedge clk);
        chk("t4_done_one_clock", done2, 0);

        // Reset in the middle of data bit 3 of 0xA5 (bit 3 is 0)
        tick_div = 2;
        base = done_cnt;
        send(0, 8'hA5, 20);
        k = 0;
        while (!(mon_in && mon_idx == 16 + 16 * 3 + 8) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("t5_reached_bit3", mon_idx, 16 + 16 * 3 + 8);
        chk("t5_tx_before_rst", tx, 0);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_tx", tx, 1);
        chk("t5_rst_ready", ready, 1);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_done", done, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("t5_no_done_on_abort", done_cnt - base, 0);
        send(0, 8'h81, 20);
        wait_done(base + 1, 2000);
        chk("t5_new_frame_done", done_cnt - base, 1);
        chk("t5_queue_empty", exp_q.size(), 0);

        // Loopback: 256 random bytes with random gaps, tick every clock
        tick_div = 1;
        base = done_cnt;
        k = mon_frames;
        for (int n = 0; n < 256; n++) begin
            repeat ($urandom_range(0, 12)) @(negedge clk);
            send(0, 8'($urandom), 1000);
        end
        wait_done(base + 256, 60000);
        chk("t6_rx_frames", mon_frames - k, 256);
        chk("t6_done_count", done_cnt - base, 256);
        chk("t6_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
